wb_trace: RTL and testbench

Retirement trace capture for the diad core. Sits directly downstream of the writeback stage: samples each committed instruction (PC, instruction word, GP target, result) and buffers it with a cycle stamp in a small show-ahead FIFO. A simulation monitor or debug port drains the FIFO through a valid/ready handshake. An arm/trigger state machine freezes capture on a chosen PC so the pipeline history leading up to an event is preserved.

---
 rtl/wb_trace_pkg.sv | 16 +
 rtl/wb_trace_fifo.sv | 55 +++++
 rtl/wb_trace.sv | 146 ++++++++++++++
 tb/tb_wb_trace.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
// Shared types and helpers for the retirement trace capture block.
package wb_trace_pkg;

  typedef enum logic [1:0] {
    TRACE_IDLE   = 2'd0,
    TRACE_RUN    = 2'd1,
    TRACE_FROZEN = 2'd2
  } trace_state_t;

  localparam int DROP_CNT_W = 8;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Show-ahead synchronous FIFO; head data is read combinationally from storage at the read pointer.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_trace.sv
// Retirement trace capture: stamps committed instructions into a show-ahead FIFO,
// with an arm/trigger state machine that freezes capture on a chosen PC.
//   state  | meaning
//   IDLE   | not capturing, waiting for arm
//   RUN    | capturing every commit
//   FROZEN | trigger PC seen, capture halted until re-arm
module wb_trace
  import wb_trace_pkg::*;
#(
  parameter int PC_WIDTH     = 24,
  parameter int INSTR_WIDTH  = 24,
  parameter int DATA_WIDTH   = 24,
  parameter int GP_SEL_WIDTH = 4,
  parameter int TICK_WIDTH   = 16,
  parameter int DEPTH        = 8
) (
  input  logic                      iw_clk,
  input  logic                      iw_rst,
  input  logic                      iw_wb_valid,
  input  logic [PC_WIDTH-1:0]       iw_wb_pc,
  input  logic [INSTR_WIDTH-1:0]    iw_wb_instr,
  input  logic                      iw_wb_we,
  input  logic [GP_SEL_WIDTH-1:0]   iw_wb_tgt_gp,
  input  logic [DATA_WIDTH-1:0]     iw_wb_result,
  input  logic                      iw_arm,
  input  logic                      iw_trig_en,
  input  logic [PC_WIDTH-1:0]       iw_trig_pc,
  input  logic                      iw_rd_ready,
  output logic                      ow_rd_valid,
  output logic [TICK_WIDTH-1:0]     ow_rd_tick,
  output logic [PC_WIDTH-1:0]       ow_rd_pc,
  output logic [INSTR_WIDTH-1:0]    ow_rd_instr,
  output logic                      ow_rd_we,
  output logic [GP_SEL_WIDTH-1:0]   ow_rd_tgt_gp,
  output logic [DATA_WIDTH-1:0]     ow_rd_result,
  output logic [$clog2(DEPTH):0]    ow_count,
  output logic [1:0]                ow_state,
  output logic                      ow_overflow,
  output logic [DROP_CNT_W-1:0]     ow_drop_cnt
);

  localparam int OFF_RES  = 0;
  localparam int OFF_GP   = OFF_RES + DATA_WIDTH;
  localparam int OFF_WE   = OFF_GP + GP_SEL_WIDTH;
  localparam int OFF_INS  = OFF_WE + 1;
  localparam int OFF_PC   = OFF_INS + INSTR_WIDTH;
  localparam int OFF_TICK = OFF_PC + PC_WIDTH;
  localparam int ENTRY_W  = OFF_TICK + TICK_WIDTH;

  trace_state_t            r_state;
  trace_state_t            w_state_nxt;
  logic                    w_clr_flags;
  logic [TICK_WIDTH-1:0]   r_tick;
  logic                    r_overflow;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;
  logic                    w_trig_hit;
  logic                    w_push_req;
  logic                    w_pop;
  logic                    w_drop;
  logic                    w_full;
  logic                    w_empty;
  logic [ENTRY_W-1:0]      w_wr_entry;
  logic [ENTRY_W-1:0]      w_rd_entry;

  assign w_trig_hit = iw_wb_valid & iw_trig_en & (iw_wb_pc == iw_trig_pc);
  assign w_push_req = (r_state == TRACE_RUN) & iw_wb_valid;
  assign w_pop      = ow_rd_valid & iw_rd_ready;
  assign w_drop     = w_push_req & w_full & ~w_pop;

  always_ff @(posedge iw_clk) begin
    if (iw_rst) r_state <= TRACE_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_flags = 1'b0;
    case (r_state)
      TRACE_IDLE: begin
        if (iw_arm) begin
          w_state_nxt = TRACE_RUN;
          w_clr_flags = 1'b1;
        end
      end
      TRACE_RUN: begin
        if (iw_arm)     w_clr_flags = 1'b1;
        if (w_trig_hit) w_state_nxt = TRACE_FROZEN;
      end
      TRACE_FROZEN: begin
        if (iw_arm) begin
          w_state_nxt = TRACE_RUN;
          w_clr_flags = 1'b1;
        end
      end
      default: w_state_nxt = TRACE_IDLE;
    endcase
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) r_tick <= '0;
    else        r_tick <= r_tick + 1'b1;
  end

  // A drop in the same cycle as a re-arm is kept so it is not silently lost.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_clr_flags) begin
      r_overflow <= w_drop;
      r_drop_cnt <= w_drop ? DROP_CNT_W'(1) : '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  assign w_wr_entry = {r_tick, iw_wb_pc, iw_wb_instr, iw_wb_we, iw_wb_tgt_gp, iw_wb_result};

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (iw_clk),
    .i_rst   (iw_rst),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_data  (w_wr_entry),
    .o_data  (w_rd_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (ow_count)
  );

  assign ow_rd_valid  = ~w_empty;
  assign ow_rd_tick   = w_rd_entry[OFF_TICK +: TICK_WIDTH];
  assign ow_rd_pc     = w_rd_entry[OFF_PC   +: PC_WIDTH];
  assign ow_rd_instr  = w_rd_entry[OFF_INS  +: INSTR_WIDTH];
  assign ow_rd_we     = w_rd_entry[OFF_WE];
  assign ow_rd_tgt_gp = w_rd_entry[OFF_GP   +: GP_SEL_WIDTH];
  assign ow_rd_result = w_rd_entry[OFF_RES  +: DATA_WIDTH];
  assign ow_state     = r_state;
  assign ow_overflow  = r_overflow;
  assign ow_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_wb_trace.sv
// Directed bench for wb_trace: reset, idle, overflow, trigger, streaming and mid-stream reset.
module tb_wb_trace;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [23:0] wb_pc;
  logic [23:0] wb_instr;
  logic        wb_we;
  logic [3:0]  wb_tgt_gp;
  logic [23:0] wb_result;
  logic        arm;
  logic        trig_en;
  logic [23:0] trig_pc;
  logic        rd_ready;
  logic        rd_valid;
  logic [15:0] rd_tick;
  logic [23:0] rd_pc;
  logic [23:0] rd_instr;
  logic        rd_we;
  logic [3:0]  rd_tgt_gp;
  logic [23:0] rd_result;
  logic [3:0]  count;
  logic [1:0]  state;
  logic        overflow;
  logic [7:0]  drop_cnt;

  logic [15:0] m_tick;
  logic [15:0] t_start;
  int          n_chk = 0;
  int          n_err = 0;

  wb_trace dut (
    .iw_clk       (clk),
    .iw_rst       (rst),
    .iw_wb_valid  (wb_valid),
    .iw_wb_pc     (wb_pc),
    .iw_wb_instr  (wb_instr),
    .iw_wb_we     (wb_we),
    .iw_wb_tgt_gp (wb_tgt_gp),
    .iw_wb_result (wb_result),
    .iw_arm       (arm),
    .iw_trig_en   (trig_en),
    .iw_trig_pc   (trig_pc),
    .iw_rd_ready  (rd_ready),
    .ow_rd_valid  (rd_valid),
    .ow_rd_tick   (rd_tick),
    .ow_rd_pc     (rd_pc),
    .ow_rd_instr  (rd_instr),
    .ow_rd_we     (rd_we),
    .ow_rd_tgt_gp (rd_tgt_gp),
    .ow_rd_result (rd_result),
    .ow_count     (count),
    .ow_state     (state),
    .ow_overflow  (overflow),
    .ow_drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference cycle stamp: what the DUT tick counter should read in the current cycle.
  always @(posedge clk) begin
    if (rst) m_tick <= 16'd0;
    else     m_tick <= m_tick + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wb_valid = 1'b0; wb_pc = '0; wb_instr = '0; wb_we = 1'b0;
    wb_tgt_gp = '0; wb_result = '0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0;
    rd_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_commit(input logic [23:0] pc, input logic [23:0] ins,
                            input logic we, input logic [3:0] gp, input logic [23:0] res);
    wb_valid = 1'b1; wb_pc = pc; wb_instr = ins; wb_we = we; wb_tgt_gp = gp; wb_result = res;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and first commit at tick 5
    do_reset();
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_head_pc", 32'(rd_pc), 32'd0);
    arm_pulse();
    chk("arm_state", 32'(state), 32'd1);
    repeat (4) step();
    set_commit(24'h000010, 24'h123456, 1'b1, 4'd3, 24'h00002A);
    step();
    wb_valid = 1'b0;
    chk("c1_valid", 32'(rd_valid), 32'd1);
    chk("c1_pc", 32'(rd_pc), 32'h10);
    chk("c1_instr", 32'(rd_instr), 32'h123456);
    chk("c1_we", 32'(rd_we), 32'd1);
    chk("c1_tgt", 32'(rd_tgt_gp), 32'd3);
    chk("c1_result", 32'(rd_result), 32'h2A);
    chk("c1_tick", 32'(rd_tick), 32'd5);
    chk("c1_count", 32'(count), 32'd1);
    step();
    chk("c1_hold_pc", 32'(rd_pc), 32'h10);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("c1_pop_valid", 32'(rd_valid), 32'd0);
    chk("c1_empty_pc", 32'(rd_pc), 32'd0);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("empty_pop_count", 32'(count), 32'd0);

    // Commits while idle are ignored
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_commit(24'h50 + 24'(i), 24'h0, 1'b0, 4'd0, 24'h0);
      step();
    end
    wb_valid = 1'b0;
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_drop", 32'(drop_cnt), 32'd0);
    chk("idle_state", 32'(state), 32'd0);

    // Overflow: 10 commits into 8 entries
    arm_pulse();
    for (int i = 0; i < 10; i++) begin
      set_commit(24'h100 + 24'(i), 24'(i), 1'b1, 4'(i), 24'(i));
      step();
    end
    wb_valid = 1'b0;
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'd2);
    chk("ovf_head", 32'(rd_pc), 32'h100);
    set_commit(24'h200, 24'h0, 1'b0, 4'd0, 24'h0);
    rd_ready = 1'b1;
    step();
    wb_valid = 1'b0;
    rd_ready = 1'b0;
    chk("full_pp_count", 32'(count), 32'd8);
    chk("full_pp_drop", 32'(drop_cnt), 32'd2);
    chk("full_pp_head", 32'(rd_pc), 32'h101);
    arm_pulse();
    chk("rearm_ovf", 32'(overflow), 32'd0);
    chk("rearm_drop", 32'(drop_cnt), 32'd0);
    chk("rearm_count", 32'(count), 32'd8);
    chk("rearm_state", 32'(state), 32'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain", 32'(rd_pc), (i < 7) ? 32'h101 + 32'(i) : 32'h200);
      step();
    end
    rd_ready = 1'b0;
    chk("ovf_drain_empty", 32'(rd_valid), 32'd0);

    // Trigger freezes capture on PC 0x20
    do_reset();
    trig_en = 1'b1;
    trig_pc = 24'h20;
    arm_pulse();
    set_commit(24'h18, 24'h0, 1'b0, 4'd0, 24'h0); step();
    set_commit(24'h1C, 24'h0, 1'b0, 4'd0, 24'h0); step();
    set_commit(24'h20, 24'h0, 1'b0, 4'd0, 24'h0); step();
    chk("trig_state", 32'(state), 32'd2);
    set_commit(24'h24, 24'h0, 1'b0, 4'd0, 24'h0); step();
    wb_valid = 1'b0;
    chk("trig_count", 32'(count), 32'd3);
    chk("trig_drop", 32'(drop_cnt), 32'd0);
    rd_ready = 1'b1;
    chk("trig_d0", 32'(rd_pc), 32'h18); step();
    chk("trig_d1", 32'(rd_pc), 32'h1C); step();
    chk("trig_d2", 32'(rd_pc), 32'h20); step();
    rd_ready = 1'b0;
    chk("trig_empty", 32'(rd_valid), 32'd0);
    trig_en = 1'b0;
    arm_pulse();
    chk("frozen_rearm", 32'(state), 32'd1);

    // Streaming with reader always ready
    do_reset();
    arm_pulse();
    rd_ready = 1'b1;
    t_start = m_tick;
    for (int i = 0; i < 20; i++) begin
      set_commit(24'h300 + 24'(i), 24'(i), 1'b0, 4'd0, 24'(i));
      step();
      chk("str_count", 32'(count), 32'd1);
      chk("str_pc", 32'(rd_pc), 32'h300 + 32'(i));
      chk("str_tick", 32'(rd_tick), 32'(t_start + 16'(i)));
    end
    wb_valid = 1'b0;
    step();
    rd_ready = 1'b0;
    chk("str_end_count", 32'(count), 32'd0);
    chk("str_drop", 32'(drop_cnt), 32'd0);
    chk("str_ovf", 32'(overflow), 32'd0);

    // Reset while holding five entries
    arm_pulse();
    for (int i = 0; i < 5; i++) begin
      set_commit(24'h400 + 24'(i), 24'h0, 1'b0, 4'd0, 24'h0);
      step();
    end
    wb_valid = 1'b0;
    chk("mid_count5", 32'(count), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_valid", 32'(rd_valid), 32'd0);
    chk("mid_state", 32'(state), 32'd0);
    chk("mid_head_pc", 32'(rd_pc), 32'd0);
    arm_pulse();
    set_commit(24'h500, 24'h0, 1'b0, 4'd0, 24'h0);
    step();
    wb_valid = 1'b0;
    chk("mid_tick_restart", 32'(rd_tick), 32'd1);
    chk("mid_head_after", 32'(rd_pc), 32'h500);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
